// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS core pipeline stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   // Default datapath and register-index widths
   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   // Load-kind encodings carried down the pipe with memory loads
   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   // Writeback stage occupancy
   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_WB        = 2'd1,
      ST_LOAD_WAIT = 2'd2
   } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a little-endian word and extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_extend
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        i_load_type,
   input  logic [1:0]        i_offset,
   input  logic [DATA_W-1:0] i_word,
   output logic [DATA_W-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection; halfword ignores offset bit 0, unknown load kinds act as LW
   always_comb begin
      w_byte = i_word[8*i_offset +: 8];
      w_half = i_word[16*i_offset[1] +: 16];
      case (i_load_type)
         LT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         LT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
         LT_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
         LT_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register and register-file write port; optional forwarding under WB_FORWARD_EN.
// Latency: one cycle from capture (or from load data return) to regWrite.
// Backpressure: wbStall holds MEM and upstream while a captured load waits for data memory.
module writeback_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memValid,
   input  logic              memRegWrite,
   input  logic              memToReg,
   input  logic [2:0]        memLoadType,
   input  logic [1:0]        memByteOffset,
   input  logic [REG_AW-1:0] memWriteRegister,
   input  logic [DATA_W-1:0] memAluResult,
   input  logic [DATA_W-1:0] dmemRdata,
   input  logic              dmemRvalid,
   output logic              regWrite,
   output logic [REG_AW-1:0] writeRegister,
   output logic [DATA_W-1:0] writeData,
   output logic              wbStall,
   output logic              fwdValid,
   output logic [REG_AW-1:0] fwdRegister,
   output logic [DATA_W-1:0] fwdData
);

   wb_state_e         r_state;
   wb_state_e         w_state_nxt;
   logic              r_reg_write;
   logic [REG_AW-1:0] r_dest;
   logic [DATA_W-1:0] r_data;
   logic [2:0]        r_load_type;
   logic [1:0]        r_offset;

   logic              w_waiting;
   logic              w_capture;
   logic [2:0]        w_ext_type;
   logic [1:0]        w_ext_offset;
   logic [DATA_W-1:0] w_ext_data;

   assign w_waiting    = (r_state == ST_LOAD_WAIT);
   assign w_capture    = !w_waiting && memValid;
   // While waiting the live MEM fields belong to a stalled instruction, so use the latched ones
   assign w_ext_type   = w_waiting ? r_load_type : memLoadType;
   assign w_ext_offset = w_waiting ? r_offset    : memByteOffset;

   load_extend #(
      .DATA_W (DATA_W)
   ) u_load_extend (
      .i_load_type (w_ext_type),
      .i_offset    (w_ext_offset),
      .i_word      (dmemRdata),
      .o_data      (w_ext_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Next-state: capture from EMPTY/WB, park in LOAD_WAIT until data returns
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD_WAIT: begin
            if (dmemRvalid) w_state_nxt = ST_WB;
         end
         default: begin
            if (!memValid)                    w_state_nxt = ST_EMPTY;
            else if (!memToReg || dmemRvalid) w_state_nxt = ST_WB;
            else                              w_state_nxt = ST_LOAD_WAIT;
         end
      endcase
   end

   // Outputs: write only from WB, never to $0; stall while a load is outstanding
   always_comb begin
      regWrite = (r_state == ST_WB) && r_reg_write && (r_dest != '0);
      wbStall  = w_waiting;
   end

   // Held instruction fields and result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_write <= 1'b0;
         r_dest      <= '0;
         r_data      <= '0;
         r_load_type <= LT_LW;
         r_offset    <= 2'b00;
      end else if (w_capture) begin
         r_reg_write <= memRegWrite;
         r_dest      <= memWriteRegister;
         r_load_type <= memLoadType;
         r_offset    <= memByteOffset;
         r_data      <= memToReg ? w_ext_data : memAluResult;
      end else if (w_waiting && dmemRvalid) begin
         r_data      <= w_ext_data;
      end
   end

   assign writeRegister = r_dest;
   assign writeData     = r_data;

`ifdef WB_FORWARD_EN
   assign fwdValid    = regWrite;
   assign fwdRegister = writeRegister;
   assign fwdData     = writeData;
`else
   assign fwdValid    = 1'b0;
   assign fwdRegister = '0;
   assign fwdData     = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a write scoreboard for writeback_stage.
// Latency checked: one cycle from capture / data return to regWrite.
// Backpressure checked: wbStall duration during a delayed load.
module tb_writeback_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        memValid, memRegWrite, memToReg, dmemRvalid;
   logic [2:0]  memLoadType;
   logic [1:0]  memByteOffset;
   logic [4:0]  memWriteRegister;
   logic [31:0] memAluResult, dmemRdata;
   logic        regWrite, wbStall, fwdValid;
   logic [4:0]  writeRegister, fwdRegister;
   logic [31:0] writeData, fwdData;

   int n_cmp = 0;
   int n_err = 0;
   logic [36:0] sb_q[$];   // {dest, data}
   logic [36:0] sb_item;

   always #5 clk = ~clk;

   writeback_stage dut (
      .clk              (clk),
      .rst              (rst),
      .memValid         (memValid),
      .memRegWrite      (memRegWrite),
      .memToReg         (memToReg),
      .memLoadType      (memLoadType),
      .memByteOffset    (memByteOffset),
      .memWriteRegister (memWriteRegister),
      .memAluResult     (memAluResult),
      .dmemRdata        (dmemRdata),
      .dmemRvalid       (dmemRvalid),
      .regWrite         (regWrite),
      .writeRegister    (writeRegister),
      .writeData        (writeData),
      .wbStall          (wbStall),
      .fwdValid         (fwdValid),
      .fwdRegister      (fwdRegister),
      .fwdData          (fwdData)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      memValid = 0; memRegWrite = 0; memToReg = 0; memLoadType = LT_LW;
      memByteOffset = 0; memWriteRegister = 0; memAluResult = 0;
      dmemRdata = 0; dmemRvalid = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input logic [4:0] dst, input logic [31:0] val, input logic we);
      memValid = 1; memRegWrite = we; memToReg = 0; memLoadType = LT_LW;
      memWriteRegister = dst; memAluResult = val; dmemRvalid = 0;
   endtask

   task automatic load_op(input logic [4:0] dst, input logic [2:0] lt, input logic [1:0] off,
                          input logic [31:0] rd, input logic rv);
      memValid = 1; memRegWrite = 1; memToReg = 1; memLoadType = lt;
      memByteOffset = off; memWriteRegister = dst; memAluResult = 32'hBAD0_BAD0;
      dmemRdata = rd; dmemRvalid = rv;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".regWrite"}, {31'd0, regWrite}, 32'd0);
      check({tag, ".writeRegister"}, {27'd0, writeRegister}, 32'd0);
      check({tag, ".writeData"}, writeData, 32'd0);
      check({tag, ".wbStall"}, {31'd0, wbStall}, 32'd0);
      check({tag, ".fwd"}, {fwdData[31:6] | fwdData[5:0], fwdValid, fwdRegister} == 32'd0 ? 32'd0 : 32'd1, 32'd0);
   endtask

   // Scoreboard: every write pulse must match the oldest expected write; fwd tracked each cycle
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (regWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_write", {27'd0, writeRegister}, 32'hFFFF_FFFF);
            end else begin
               sb_item = sb_q.pop_front();
               check("wr_reg", {27'd0, writeRegister}, {27'd0, sb_item[36:32]});
               check("wr_data", writeData, sb_item[31:0]);
            end
         end
`ifdef WB_FORWARD_EN
         check("fwd_valid", {31'd0, fwdValid}, {31'd0, regWrite});
         if (regWrite === 1'b1) begin
            check("fwd_reg", {27'd0, fwdRegister}, {27'd0, writeRegister});
            check("fwd_data", fwdData, writeData);
         end
`else
         check("fwd_off", {fwdValid, fwdRegister, fwdData[25:0]} | {6'd0, fwdData[31:26]}, 32'd0);
`endif
      end
   end

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      check_all_zero("reset");
      check("reset.state", {30'd0, dut.r_state}, {30'd0, ST_EMPTY});
      rst = 0;

      // ALU op, dest 8
      alu_op(5'd8, 32'h1234_5678, 1'b1); sb_q.push_back({5'd8, 32'h1234_5678});
      tick(); idle();
      check("alu.regWrite", {31'd0, regWrite}, 32'd1);
      check("alu.wbStall", {31'd0, wbStall}, 32'd0);
      tick();
      check("alu.one_cycle", {31'd0, regWrite}, 32'd0);

      // Write to $0 is suppressed but the stage still holds it
      alu_op(5'd0, 32'hCAFE_0000, 1'b1);
      tick(); idle();
      check("r0.regWrite", {31'd0, regWrite}, 32'd0);
      check("r0.state", {30'd0, dut.r_state}, {30'd0, ST_WB});
      tick();

      // LB / LBU offset 2 with data in the capture cycle
      load_op(5'd9, LT_LB, 2'd2, 32'h00F0_0000, 1'b1); sb_q.push_back({5'd9, 32'hFFFF_FFF0});
      tick();
      load_op(5'd10, LT_LBU, 2'd2, 32'h00F0_0000, 1'b1); sb_q.push_back({5'd10, 32'h0000_00F0});
      tick();
      check("lbu.data", writeData, 32'h0000_00F0);
      // LHU offset 1 (bit 0 ignored) and undefined encoding acting as LW
      load_op(5'd14, LT_LHU, 2'd1, 32'h1234_8765, 1'b1); sb_q.push_back({5'd14, 32'h0000_8765});
      tick();
      load_op(5'd15, 3'b111, 2'd3, 32'hDEAD_BEEF, 1'b1); sb_q.push_back({5'd15, 32'hDEAD_BEEF});
      tick();
      // Back-to-back ALU ops, one write per cycle
      for (int i = 0; i < 3; i++) begin
         alu_op(5'(16 + i), 32'h1000_0000 + i, 1'b1);
         sb_q.push_back({5'(16 + i), 32'h1000_0000 + i});
         tick();
         check("b2b.regWrite", {31'd0, regWrite}, 32'd1);
      end
      idle(); tick();

      // LH offset 3, data 3 cycles late; MEM keeps presenting junk that must be ignored
      load_op(5'd11, LT_LH, 2'd3, 32'h0000_0000, 1'b0); sb_q.push_back({5'd11, 32'hFFFF_8001});
      tick();
      alu_op(5'd12, 32'h5555_5555, 1'b1);
      for (int c = 0; c < 3; c++) begin
         check("lh.wbStall", {31'd0, wbStall}, 32'd1);
         if (c == 2) begin
            dmemRdata = 32'h8001_0000; dmemRvalid = 1;
         end
         tick();
      end
      idle();
      check("lh.stall_fall", {31'd0, wbStall}, 32'd0);
      check("lh.data", writeData, 32'hFFFF_8001);
      tick();
      check("lh.state", {30'd0, dut.r_state}, {30'd0, ST_EMPTY});

      // Reset while a load is outstanding, then a late dmemRvalid
      load_op(5'd13, LT_LW, 2'd0, 32'h0, 1'b0);
      tick(); idle();
      check("rstld.wbStall", {31'd0, wbStall}, 32'd1);
      rst = 1;
      tick();
      rst = 0;
      check_all_zero("rstld");
      dmemRdata = 32'h7777_7777; dmemRvalid = 1;
      tick(); idle();
      check_all_zero("rstld.late");
      tick();
      check_all_zero("rstld.after");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
